// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: digit width, debounce states
// and a counter-width helper.
package keypad_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } deb_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Synchronizes the raw decoder valid/number pair and debounces it into one
// strobe per physical press; a press must also be released cleanly to re-arm.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic [DIGIT_W-1:0] i_number,
    output logic               o_key_strobe,
    output logic [DIGIT_W-1:0] o_key_value,
    output logic [DIGIT_W-1:0] o_accept_digit
);

    localparam int               CNT_W   = width_for(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic               r_valid_meta;
    logic               r_valid_s;
    logic [DIGIT_W-1:0] r_number_meta;
    logic [DIGIT_W-1:0] r_number_s;

    deb_state_t         r_state;
    logic [DIGIT_W-1:0] r_cand;
    logic [DIGIT_W-1:0] r_key_value;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_same;
    logic               w_cnt_done;
    logic               w_accept;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid_meta  <= 1'b0;
            r_valid_s     <= 1'b0;
            r_number_meta <= '0;
            r_number_s    <= '0;
        end else begin
            r_valid_meta  <= i_valid;
            r_valid_s     <= r_valid_meta;
            r_number_meta <= i_number;
            r_number_s    <= r_number_meta;
        end
    end

    assign w_same     = r_valid_s && (r_number_s == r_cand);
    assign w_cnt_done = (r_cnt == CNT_MAX);
    // Accept is a decode of registered state so the strobe lands in the same
    // cycle the final stable sample is visible, with no extra register stage.
    assign w_accept   = (r_state == PRESS_WAIT) && w_same && w_cnt_done;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_key_value <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_valid_s) begin
                        r_cand  <= r_number_s;
                        r_cnt   <= CNT_ONE;
                        r_state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_same) begin
                        r_state <= IDLE;
                    end else if (w_cnt_done) begin
                        r_key_value <= r_cand;
                        r_state     <= HELD;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    // Digit changes while held are ignored: no rollover.
                    if (!r_valid_s) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    if (r_valid_s) begin
                        r_state <= HELD;
                    end else if (w_cnt_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_key_strobe   = w_accept;
    assign o_key_value    = r_key_value;
    assign o_accept_digit = r_cand;

endmodule

// File: rtl/keypad_entry.sv
// Collects debounced key presses into a DIGITS-long BCD code and hands the
// completed code to the consumer over a valid/ready handshake.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic [DIGIT_W-1:0]            i_number,
    input  logic                          i_clear_code,
    input  logic                          i_code_ready,
    output logic                          o_key_strobe,
    output logic [DIGIT_W-1:0]            o_key_value,
    output logic [DIGIT_W*DIGITS-1:0]     o_code,
    output logic                          o_code_valid,
    output logic [$clog2(DIGITS+1)-1:0]   o_digit_count,
    output logic                          o_overflow
);

    localparam int               CODE_W   = DIGIT_W * DIGITS;
    localparam int               CNT_W    = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                 w_strobe;
    logic [DIGIT_W-1:0]   w_digit;
    logic                 w_handshake;
    logic [CODE_W-1:0]    w_shifted;
    logic [CNT_W-1:0]     w_count_inc;

    logic [CODE_W-1:0]    r_code;
    logic [CNT_W-1:0]     r_count;
    logic                 r_code_valid;
    logic                 r_overflow;

    keypad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_valid        (i_valid),
        .i_number       (i_number),
        .o_key_strobe   (w_strobe),
        .o_key_value    (o_key_value),
        .o_accept_digit (w_digit)
    );

    generate
        if (DIGITS == 1) begin : g_shift_one
            assign w_shifted = w_digit;
        end else begin : g_shift_many
            assign w_shifted = {r_code[CODE_W-DIGIT_W-1:0], w_digit};
        end
    endgenerate

    assign w_handshake = r_code_valid && i_code_ready;
    assign w_count_inc = r_count + CNT_ONE;

    // Priority: clear, then handshake (a coincident press starts the next
    // code), then plain accumulation or overflow.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_code       <= '0;
            r_count      <= '0;
            r_code_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (i_clear_code) begin
            r_code       <= '0;
            r_count      <= '0;
            r_code_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_handshake) begin
            r_overflow <= 1'b0;
            if (w_strobe) begin
                r_code       <= CODE_W'(w_digit);
                r_count      <= CNT_ONE;
                r_code_valid <= (DIGITS == 1);
            end else begin
                r_code       <= '0;
                r_count      <= '0;
                r_code_valid <= 1'b0;
            end
        end else if (w_strobe) begin
            if (r_code_valid) begin
                r_overflow <= 1'b1;
            end else begin
                r_code       <= w_shifted;
                r_count      <= w_count_inc;
                r_code_valid <= (w_count_inc == CNT_FULL);
            end
        end
    end

    assign o_key_strobe  = w_strobe;
    assign o_code        = r_code;
    assign o_code_valid  = r_code_valid;
    assign o_digit_count = r_count;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed presses plus random valid/number traffic,
// checked every cycle against a run-length model of the debounce rules and a
// digit-queue model of the code buffer.
module tb_keypad_entry;

    localparam int D  = 4;
    localparam int N  = 4;
    localparam int CW = 4 * N;
    localparam int NW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [3:0]    number = 4'd0;
    logic          clear_code = 1'b0;
    logic          code_ready = 1'b0;

    logic          o_key_strobe;
    logic [3:0]    o_key_value;
    logic [CW-1:0] o_code;
    logic          o_code_valid;
    logic [NW-1:0] o_digit_count;
    logic          o_overflow;

    always #5 clk = ~clk;

    keypad_entry #(.DEBOUNCE_CYCLES(D), .DIGITS(N)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_valid       (valid),
        .i_number      (number),
        .i_clear_code  (clear_code),
        .i_code_ready  (code_ready),
        .o_key_strobe  (o_key_strobe),
        .o_key_value   (o_key_value),
        .o_code        (o_code),
        .o_code_valid  (o_code_valid),
        .o_digit_count (o_digit_count),
        .o_overflow    (o_overflow)
    );

    int n_chk = 0;
    int n_fail = 0;
    int strobes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: synchronizer as a 2-sample delay; a press is a run of D+1
    // valid samples while unpressed, a release is a run of D+1 idle samples.
    logic       m_d1v = 1'b0;
    logic [3:0] m_d1n = 4'd0;
    logic       m_curv = 1'b0;
    logic [3:0] m_curn = 4'd0;
    bit         m_pressed = 1'b0;
    int         m_ones = 0;
    int         m_zeros = 0;
    bit         m_strobe = 1'b0;
    logic [3:0] m_digit = 4'd0;
    logic [3:0] m_key = 4'd0;
    logic [3:0] m_q[$];
    bit         m_ovf = 1'b0;

    function automatic logic [CW-1:0] model_code();
        logic [CW-1:0] c;
        c = '0;
        foreach (m_q[i]) c = {c[CW-5:0], m_q[i]};
        return c;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_d1v = 0; m_d1n = 0; m_curv = 0; m_curn = 0;
            m_pressed = 0; m_ones = 0; m_zeros = 0;
            m_strobe = 0; m_digit = 0; m_key = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            if (clear_code) begin
                m_q.delete();
                m_ovf = 0;
            end else if (m_q.size() == N && code_ready) begin
                m_q.delete();
                m_ovf = 0;
            end
            if (m_strobe) begin
                m_key = m_digit;
                if (!clear_code) begin
                    if (m_q.size() == N) m_ovf = 1;
                    else m_q.push_back(m_digit);
                end
            end
            m_curv = m_d1v; m_curn = m_d1n;
            m_d1v = valid;  m_d1n = number;
            m_strobe = 0;
            if (!m_pressed) begin
                m_ones = m_curv ? m_ones + 1 : 0;
                if (m_ones == D + 1) begin
                    m_strobe = 1; m_digit = m_curn; m_pressed = 1; m_zeros = 0;
                end
            end else begin
                m_zeros = m_curv ? 0 : m_zeros + 1;
                if (m_zeros == D + 1) begin
                    m_pressed = 0; m_ones = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (o_key_strobe) strobes++;
        chk("key_strobe",  o_key_strobe,  m_strobe);
        chk("key_value",   o_key_value,   m_key);
        chk("code",        o_code,        model_code());
        chk("code_valid",  o_code_valid,  (m_q.size() == N));
        chk("digit_count", o_digit_count, m_q.size());
        chk("overflow",    o_overflow,    m_ovf);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Returns the number of edges from the next edge to the strobe cycle;
    // leaves the caller at the negedge inside the strobe cycle.
    task automatic wait_strobe(input string nm, output int n);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (o_key_strobe) return;
        end
        n = -1;
        n_chk++;
        n_fail++;
        $display("FAIL %s: no key_strobe within 40 cycles", nm);
    endtask

    task automatic release_key();
        repeat (4) step();
        valid = 0;
        repeat (D + 8) step();
    endtask

    task automatic press(input logic [3:0] d, output int lat);
        number = d;
        valid = 1;
        wait_strobe("press_wait", lat);
        release_key();
    endtask

    int   seq4[4] = '{1, 2, 3, 4};
    int   seq3[3] = '{1, 2, 3};
    logic pat[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int lat, s0, len;
        repeat (3) step();
        chk("rst_code", o_code, 0);
        chk("rst_strobe", o_key_strobe, 0);
        chk("rst_valid", o_code_valid, 0);
        rst_n = 1;
        step();

        s0 = strobes;
        press(4'd5, lat);
        chk("press_latency", lat, D + 2);
        chk("press_strobes", strobes - s0, 1);
        chk("press_key", o_key_value, 5);
        chk("press_code", o_code, 16'h0005);
        chk("press_count", o_digit_count, 1);
        chk("press_cv", o_code_valid, 0);

        s0 = strobes;
        number = 4'd6;
        foreach (pat[i]) begin
            valid = pat[i];
            step();
        end
        chk("bounce_quiet", strobes - s0, 0);
        valid = 1;
        wait_strobe("bounce_wait", lat);
        chk("bounce_latency", lat, D + 2);
        repeat (4) step();
        valid = 0; step();
        valid = 1; step();
        valid = 0;
        repeat (D + 8) step();
        chk("bounce_strobes", strobes - s0, 1);
        chk("bounce_code", o_code, 16'h0056);

        clear_code = 1; step(); clear_code = 0; step();
        chk("clear_code", o_code, 0);
        chk("clear_count", o_digit_count, 0);

        foreach (seq4[i]) press(4'(seq4[i]), lat);
        chk("full_code", o_code, 16'h1234);
        chk("full_cv", o_code_valid, 1);
        chk("full_count", o_digit_count, 4);

        press(4'd7, lat);
        chk("ovf_key", o_key_value, 7);
        chk("ovf_code", o_code, 16'h1234);
        chk("ovf_flag", o_overflow, 1);

        code_ready = 1; step(); code_ready = 0;
        chk("hs_cv", o_code_valid, 0);
        chk("hs_code", o_code, 0);
        chk("hs_count", o_digit_count, 0);
        chk("hs_ovf", o_overflow, 0);

        foreach (seq4[i]) press(4'(seq4[i]), lat);
        number = 4'd9;
        valid = 1;
        wait_strobe("coin_wait", lat);
        code_ready = 1; step(); code_ready = 0;
        chk("coin_code", o_code, 16'h0009);
        chk("coin_cv", o_code_valid, 0);
        chk("coin_count", o_digit_count, 1);
        release_key();

        foreach (seq3[i]) press(4'(seq3[i]), lat);
        chk("refill_code", o_code, 16'h9123);
        s0 = strobes;
        number = 4'd8;
        valid = 1;
        wait_strobe("clr_wait", lat);
        clear_code = 1; code_ready = 1; step();
        clear_code = 0; code_ready = 0;
        chk("clr_code", o_code, 0);
        chk("clr_count", o_digit_count, 0);
        chk("clr_cv", o_code_valid, 0);
        chk("clr_strobes", strobes - s0, 1);
        chk("clr_key", o_key_value, 8);
        release_key();

        s0 = strobes;
        number = 4'd2;
        valid = 1;
        wait_strobe("roll_wait", lat);
        step();
        number = 4'd5;
        release_key();
        chk("roll_strobes", strobes - s0, 1);
        chk("roll_key", o_key_value, 2);
        chk("roll_code", o_code, 16'h0002);

        number = 4'd3;
        valid = 1;
        repeat (4) step();
        #1 rst_n = 0;
        #1;
        chk("arst_strobe", o_key_strobe, 0);
        chk("arst_key", o_key_value, 0);
        chk("arst_code", o_code, 0);
        chk("arst_count", o_digit_count, 0);
        chk("arst_cv", o_code_valid, 0);
        chk("arst_ovf", o_overflow, 0);
        step();
        rst_n = 1;
        wait_strobe("arst_wait", lat);
        chk("arst_latency", lat, D + 2);
        release_key();

        repeat (160) begin
            if (!valid) number = 4'($urandom_range(0, 15));
            valid = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            repeat (len) begin
                clear_code = ($urandom_range(0, 39) == 0);
                code_ready = ($urandom_range(0, 5) == 0);
                step();
            end
        end
        clear_code = 0;
        code_ready = 0;
        valid = 0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
